// File: rtl/fastica_iteration_ctrl_pkg.sv
// Shared types for the FastICA iteration controller: the IEEE-754 double
// container and the iteration FSM state encoding (mirrors fsm_conv).
package fastica_iteration_ctrl_pkg;

  // Raw IEEE-754 binary64 bit pattern; no arithmetic is done on it here.
  typedef logic [63:0] double;

  // Iteration loop states; XXX_IT is only ever a default-assignment value.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    UPD_ISSUE  = 4'd1,
    UPD_WAIT   = 4'd2,
    CHK_CLEAR  = 4'd3,
    CHK_ISSUE  = 4'd4,
    CHK_WAIT   = 4'd5,
    CHK_SETTLE = 4'd6,
    EVAL       = 4'd7,
    DONE       = 4'd8,
    XXX_IT     = 4'd15
  } state_iter;

  // True in the two states where a new run may be accepted.
  function automatic logic is_idle_or_done(input state_iter s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/vector_reg_bank.sv
// Loadable bank of SIZE_N doubles with asynchronous clear.
module vector_reg_bank
  import fastica_iteration_ctrl_pkg::*;
#(
  parameter int SIZE_N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  double [SIZE_N-1:0]  d,
  output double [SIZE_N-1:0]  q
);

  double [SIZE_N-1:0] q_r;

  // Capture the whole vector on load; clear asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fastica_iteration_ctrl.sv
// FastICA fixed-point iteration controller: sequences the vector-update unit
// and the convergence checker until convergence or MAX_ITER iterations.
module fastica_iteration_ctrl
  import fastica_iteration_ctrl_pkg::*;
#(
  parameter int SIZE_N   = 8,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = $clog2(MAX_ITER + 1),
  parameter int CMP_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  double [SIZE_N-1:0]  init_vector,
  output logic                upd_start,
  input  logic                upd_done,
  input  double [SIZE_N-1:0]  upd_vector,
  output double [SIZE_N-1:0]  cur_vector,
  output double [SIZE_N-1:0]  nxt_vector,
  output logic                chk_rst,
  output logic                chk_start,
  input  logic                chk_f,
  input  logic                chk_converged,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic                timeout,
  output logic [ITER_W-1:0]   iter_count
);

  // A zero-latency comparator still needs a 1-bit counter to keep widths legal.
  localparam int SETTLE_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(CMP_LAT);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [ITER_W-1:0]   LAST_ITER   = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0]   ITER_ONE    = ITER_W'(1);

  state_iter           state_r;
  state_iter           next_s;
  logic [SETTLE_W-1:0] settle_r;
  logic [ITER_W-1:0]   iter_r;
  logic                conv_r;
  logic                tout_r;
  logic                accept_s;
  logic                cur_load_s;
  logic                nxt_load_s;
  double [SIZE_N-1:0]  cur_d_s;

  // Next-state decode; every transition is driven by state plus a sampled input.
  always_comb begin
    next_s = XXX_IT;
    case (state_r)
      IDLE, DONE: begin
        if (start) next_s = UPD_ISSUE;
        else       next_s = state_r;
      end
      UPD_ISSUE:  next_s = UPD_WAIT;
      UPD_WAIT: begin
        if (upd_done) next_s = CHK_CLEAR;
        else          next_s = UPD_WAIT;
      end
      CHK_CLEAR:  next_s = CHK_ISSUE;
      CHK_ISSUE:  next_s = CHK_WAIT;
      CHK_WAIT: begin
        if (!chk_f)            next_s = CHK_WAIT;
        else if (CMP_LAT == 0) next_s = EVAL;
        else                   next_s = CHK_SETTLE;
      end
      CHK_SETTLE: begin
        if (settle_r <= SETTLE_ONE) next_s = EVAL;
        else                        next_s = CHK_SETTLE;
      end
      EVAL: begin
        // Convergence wins over timeout on the last permitted iteration.
        if (chk_converged)            next_s = DONE;
        else if (iter_r == LAST_ITER) next_s = DONE;
        else                          next_s = UPD_ISSUE;
      end
      default:    next_s = IDLE;
    endcase
  end

  // Vector-bank load controls: init on accepted start, promote nxt in EVAL.
  always_comb begin
    accept_s   = 1'b0;
    cur_load_s = 1'b0;
    cur_d_s    = nxt_vector;
    nxt_load_s = 1'b0;
    if (start && is_idle_or_done(state_r)) begin
      accept_s   = 1'b1;
      cur_load_s = 1'b1;
      cur_d_s    = init_vector;
    end else if (state_r == EVAL) begin
      cur_load_s = 1'b1;
      cur_d_s    = nxt_vector;
    end else begin
      cur_load_s = 1'b0;
    end
    if ((state_r == UPD_WAIT) && upd_done) nxt_load_s = 1'b1;
    else                                   nxt_load_s = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Settle counter covering the comparator latency after chk_f rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_r <= '0;
    end else if ((state_r == CHK_WAIT) && chk_f) begin
      settle_r <= SETTLE_INIT;
    end else if (state_r == CHK_SETTLE) begin
      settle_r <= settle_r - SETTLE_ONE;
    end
  end

  // Run status: iteration count and the mutually exclusive end reasons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_r <= '0;
      conv_r <= 1'b0;
      tout_r <= 1'b0;
    end else if (accept_s) begin
      iter_r <= '0;
      conv_r <= 1'b0;
      tout_r <= 1'b0;
    end else if (state_r == EVAL) begin
      iter_r <= iter_r + ITER_ONE;
      if (chk_converged)            conv_r <= 1'b1;
      else if (iter_r == LAST_ITER) tout_r <= 1'b1;
    end
  end

  vector_reg_bank #(.SIZE_N(SIZE_N)) u_cur_bank (
    .clk  (clk),
    .rst  (rst),
    .load (cur_load_s),
    .d    (cur_d_s),
    .q    (cur_vector)
  );

  vector_reg_bank #(.SIZE_N(SIZE_N)) u_nxt_bank (
    .clk  (clk),
    .rst  (rst),
    .load (nxt_load_s),
    .d    (upd_vector),
    .q    (nxt_vector)
  );

  assign upd_start  = (state_r == UPD_ISSUE);
  assign chk_start  = (state_r == CHK_ISSUE);
  assign chk_rst    = is_idle_or_done(state_r) || (state_r == CHK_CLEAR);
  assign busy       = !is_idle_or_done(state_r);
  assign done       = (state_r == DONE);
  assign converged  = conv_r;
  assign timeout    = tout_r;
  assign iter_count = iter_r;

endmodule

// File: doc/fastica_iteration_ctrl.md
# fastica_iteration_ctrl

Controller that runs the fixed-point iteration loop of the unmixing-vector estimator. It keeps the current vector and starts the external vector-update unit. It then re-arms and starts the `convergence_check` unit on each update. The loop ends on convergence or after a bounded number of iterations. It sits between the top-level sequencer (start/done) and the update and convergence datapaths.

## Interface
- SIZE_N, 8, vector length (elements of `double`)
- MAX_ITER, 64, iteration limit (≥1)
- ITER_W, $clog2(MAX_ITER+1), iteration counter width
- CMP_LAT, 2, cycles between checker `f` rising and `converged` being valid (fp_gt latency)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; honoured only in IDLE or DONE
- init_vector  in  double[SIZE_N][1]  initial vector, sampled on accepted start
- upd_start  out  1  one-cycle pulse to the update unit
- upd_done  in  1  update result valid; sampled only in UPD_WAIT
- upd_vector  in  double[SIZE_N][1]  updated vector, captured when upd_done is sampled
- cur_vector  out  double[SIZE_N][1]  current vector register; feeds the update unit and checker `vector`
- nxt_vector  out  double[SIZE_N][1]  captured update; feeds checker `next_vector`
- chk_rst  out  1  local clear to the checker's rst input
- chk_start  out  1  one-cycle pulse to the checker
- chk_f  in  1  checker finished (level, held until cleared); sampled only in CHK_WAIT
- chk_converged  in  1  checker verdict; sampled only in EVAL
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level, high in DONE
- converged  out  1  run ended by convergence (valid with done)
- timeout  out  1  run ended by MAX_ITER (valid with done)
- iter_count  out  ITER_W  completed iterations

## Operation
- States: IDLE, UPD_ISSUE, UPD_WAIT, CHK_CLEAR, CHK_ISSUE, CHK_WAIT, CHK_SETTLE, EVAL, DONE.
- IDLE/DONE + start: load cur_vector from init_vector; iter_count, converged, timeout <= 0; go to UPD_ISSUE.
- UPD_ISSUE: assert upd_start; go to UPD_WAIT.
- UPD_WAIT: when upd_done is sampled, capture nxt_vector <= upd_vector and go to CHK_CLEAR.
- CHK_CLEAR: assert chk_rst; go to CHK_ISSUE.
- CHK_ISSUE: assert chk_start; go to CHK_WAIT.
- CHK_WAIT: when chk_f is sampled, load the settle counter with CMP_LAT and go to CHK_SETTLE.
- CHK_SETTLE: decrement the settle counter; go to EVAL when it reaches 0. With CMP_LAT=0, skip straight to EVAL.
- EVAL:
  - cur_vector <= nxt_vector; iter_count += 1.
  - If chk_converged: converged <= 1, go to DONE.
  - Else if iter_count+1 == MAX_ITER: timeout <= 1, go to DONE.
  - Else go to UPD_ISSUE.
- Convergence takes priority over timeout on the final iteration. converged and timeout are never both 1.
- chk_rst = 1 in IDLE, DONE and CHK_CLEAR. This keeps the checker's latched FINISHED state cleared before every start.
- start while busy: ignored.
- upd_done or chk_f outside their wait states: ignored.
- iter_count saturates by construction at MAX_ITER; it never wraps.

## Timing
- Reset values: all outputs 0 except chk_rst = 1. cur_vector and nxt_vector are 0. State is IDLE.
- Reset mid-run: immediate return to IDLE; no pulses are emitted afterwards.
- All outputs are registered or pure state decodes; there are no combinational input-to-output paths.
- upd_start and chk_start are exactly one cycle wide and occur once per iteration.
- Cycles per iteration: 1 + U + 1 + 1 + C + CMP_LAT + 1, where:
  - U = cycles in UPD_WAIT, including the upd_done cycle.
  - C = cycles in CHK_WAIT, including the chk_f cycle.
- done rises one cycle after the final EVAL and holds until start or rst.
- cur_vector, iter_count, converged and timeout are stable throughout DONE.

## Structure
- Package fsm_iter: enum state_iter (the nine states above plus XXX_IT as the default-assignment value). This mirrors fsm_conv.
- The `double` type comes from fp_double.
- One natural sub-module: vector_reg_bank #(SIZE_N). It is a loadable double[SIZE_N][1] register with async clear, instantiated for cur_vector and nxt_vector.
- Structure: FSM in always_comb with a default next = XXX_IT, plus an always_ff with async rst.

## Test plan
- Converge on 3rd verdict (MAX_ITER=64; checker model returns converged 0,0,1) -> done=1, converged=1, timeout=0, iter_count=3; 3 upd_start pulses, 3 chk_start pulses, chk_rst high in each CHK_CLEAR.
- Never converge (MAX_ITER=4) -> done after 4th EVAL, timeout=1, converged=0, iter_count=4; exactly 4 upd_start pulses.
- Converge on the final iteration (MAX_ITER=2; verdicts 0,1) -> converged=1, timeout=0, iter_count=2.
- Vector path: init_vector all 64'h3FF0000000000000 (1.0), update returns 64'h4000000000000000 (2.0) -> nxt_vector = 2.0 from CHK_CLEAR; cur_vector = 2.0 after EVAL.
- Glitch immunity: upd_done pulsed in UPD_ISSUE and chk_f held high during CHK_CLEAR -> no premature transition. Start pulsed in CHK_WAIT -> ignored, iter_count unchanged.
- Reset asserted mid-CHK_SETTLE -> all outputs 0, chk_rst=1, IDLE. A subsequent start completes a clean run; restart from DONE clears converged/timeout and reloads init_vector.
